// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage register with valid/ready handshake, 2-entry skid and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_buf #(
    parameter int WIDTH          = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             issue;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Handshake outputs decode the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_n      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && issue) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (issue) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (issue) begin
                    state_n        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Bubbles leave with an all-zero control word when clearing is enabled.
    always_ff @(posedge clk) begin
        if (reset || (flush && CLEAR_ON_FLUSH)) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Counters see the pre-flush state and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (!out_valid) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: vector table, FIFO scoreboard and randomized backpressure.
// With PIPE_STAGE_PERF_EN defined it also exercises the counters at CNT_WIDTH = 4.
module tb_pipe_stage_buf;

    localparam int W = 64;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        bit           rst;
        bit           fl;
        bit           iv;
        logic [W-1:0] d;
        bit           ordy;
        logic [1:0]   occ;
        logic         ov;
        logic         ir;
        logic [W-1:0] od;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .WIDTH(W),
        .CLEAR_ON_FLUSH(1'b1),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: scoreboard bookkeeping on the current handshake, then check structure after the edge.
    task automatic step();
        if (out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_issue: got %0h, expected no valid output", out_data);
            end else begin
                chk("issue_order", out_data, sb.pop_front());
            end
        end
        if (in_valid && in_ready === 1'b1 && !flush && !reset) sb.push_back(in_data);
        @(posedge clk);
        if (reset || flush) sb.delete();
        @(negedge clk);
        chk("occ_vs_sb", {62'd0, occupancy}, W'(sb.size()));
        chk("ovalid_vs_sb", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        chk("iready_vs_sb", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit o);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
    endtask

    task automatic add(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit o,
                       input logic [1:0] occ, input logic ov, input logic ir, input logic [W-1:0] od);
        vec_t v;
        v.rst = r; v.fl = f; v.iv = iv; v.d = d; v.ordy = o;
        v.occ = occ; v.ov = ov; v.ir = ir; v.od = od;
        tv.push_back(v);
    endtask

    initial begin
        // Reset, then X payload with in_valid low
        add(1, 0, 0, 64'h0,  0, 2'd0, 0, 1, 64'h0);
        add(0, 0, 0, 'x,     0, 2'd0, 0, 1, 64'h0);
        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) add(0, 0, 1, W'(i), 1, 2'd1, 1, 1, W'(i));
        add(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'h8);
        // Backpressure fill and drain
        add(0, 0, 1, 64'hA,  1, 2'd1, 1, 1, 64'hA);
        add(0, 0, 1, 64'hB,  0, 2'd2, 1, 0, 64'hA);
        add(0, 0, 1, 64'hC,  0, 2'd2, 1, 0, 64'hA);
        add(0, 0, 1, 64'hC,  1, 2'd1, 1, 1, 64'hB);
        add(0, 0, 1, 64'hC,  1, 2'd1, 1, 1, 64'hC);
        add(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'hC);
        // Flush when FULL with a payload offered
        add(0, 0, 1, 64'hA,  0, 2'd1, 1, 1, 64'hA);
        add(0, 0, 1, 64'hB,  0, 2'd2, 1, 0, 64'hA);
        add(0, 1, 1, 64'hC,  0, 2'd0, 0, 1, 64'h0);
        add(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'h0);
        // Reset together with flush and accept mid-stream, then first accept after reset
        add(0, 0, 1, 64'h11, 1, 2'd1, 1, 1, 64'h11);
        add(1, 1, 1, 64'h22, 1, 2'd0, 0, 1, 64'h0);
        add(0, 0, 1, 64'h33, 0, 2'd1, 1, 1, 64'h33);
        add(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'h33);

        drive(1, 0, 0, '0, 0);
        @(negedge clk);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].d, tv[i].ordy);
            step();
            chk($sformatf("v%0d_occ", i),   {62'd0, occupancy}, {62'd0, tv[i].occ});
            chk($sformatf("v%0d_ovalid", i), {63'd0, out_valid}, {63'd0, tv[i].ov});
            chk($sformatf("v%0d_iready", i), {63'd0, in_ready},  {63'd0, tv[i].ir});
            chk($sformatf("v%0d_odata", i),  out_data, tv[i].od);
        end

        // Randomized traffic with occasional flush; the scoreboard checks order and occupancy
        for (int c = 0; c < 400; c++) begin
            drive(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
            step();
        end
        // Drain whatever is left
        drive(0, 0, 0, '0, 1);
        for (int c = 0; c < 3; c++) step();
        chk("drained_occ", {62'd0, occupancy}, 64'd0);

`ifdef PIPE_STAGE_PERF_EN
        drive(1, 0, 0, '0, 0);
        step();
        chk("cnt_reset_stall",  W'(stall_cnt),  64'd0);
        chk("cnt_reset_bubble", W'(bubble_cnt), 64'd0);
        // Two idle cycles plus the accept cycle make three bubble cycles
        drive(0, 0, 0, '0, 0);
        step();
        step();
        drive(0, 0, 1, 64'h5, 0);
        step();
        drive(0, 0, 0, '0, 0);
        for (int c = 0; c < 20; c++) step();
        chk("cnt_bubble_3",     W'(bubble_cnt), 64'd3);
        chk("cnt_stall_sat",    W'(stall_cnt),  64'd15);
        drive(0, 1, 0, '0, 0);
        step();
        chk("cnt_flush_stall",  W'(stall_cnt),  64'd15);
        chk("cnt_flush_bubble", W'(bubble_cnt), 64'd3);
        drive(1, 0, 0, '0, 0);
        step();
        chk("cnt_rst_stall",    W'(stall_cnt),  64'd0);
        chk("cnt_rst_bubble",   W'(bubble_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
